// File: rtl/mc_main_fsm.sv
// Multi-cycle RV32I main sequencing controller: Moore FSM driving datapath enables/selects.
// Define MC_MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on mem_ready; otherwise memory is always ready.
module mc_main_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             PCUpdate,
    output logic             Branch,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ResultSrc,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  instret_q;
    logic              mem_ok;
    logic              op_legal;
    logic              retire;

`ifdef MC_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BR:        state_d = S_BRANCH;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ok ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ok ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // An instruction retires on the edge that returns from its last state to FETCH.
    assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
                    ((state_q == S_MEMWRITE) && mem_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    always_comb begin
        IRWrite   = 1'b0;
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        ResultSrc = 2'b00;
        illegal   = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    IRWrite   = mem_ok;
                    PCUpdate  = mem_ok;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    illegal = !op_legal;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD:  AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b10;
                end
                S_EXECI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ALUOp   = 2'b10;
                end
                S_ALUWB:    RegWrite = 1'b1;
                S_JAL: begin
                    ALUSrcA  = 2'b01;
                    ALUSrcB  = 2'b10;
                    PCUpdate = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b01;
                    Branch  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Scoreboard bench for mc_main_fsm: drivers queue per-cycle expected outputs, a negedge monitor checks them.
module tb_mc_main_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0;
    logic       mem_ready = 1'b1;
    logic       IRWrite, PCUpdate, Branch, RegWrite, MemWrite, AdrSrc, illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic [3:0] instret;
    logic [3:0] state;

    logic [22:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cnt = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    mc_main_fsm #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ResultSrc(ResultSrc), .illegal(illegal), .instret(instret),
        .state(state)
    );

    // {state, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal, instret}
    function automatic logic [22:0] pack(input logic [3:0] s, input logic irw, input logic pcu,
                                         input logic br, input logic rw, input logic mw,
                                         input logic adr, input logic [1:0] asa, input logic [1:0] asb,
                                         input logic [1:0] aop, input logic [1:0] rs,
                                         input logic ill, input logic [3:0] c);
        return {s, irw, pcu, br, rw, mw, adr, asa, asb, aop, rs, ill, c};
    endfunction

    // Output table taken from the per-state list of the controller description.
    function automatic logic [22:0] model(input logic [3:0] s, input logic ill, input logic [3:0] c);
        case (s)
            4'd0:  return pack(s, 1, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, c);
            4'd1:  return pack(s, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, ill, c);
            4'd2:  return pack(s, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, c);
            4'd3:  return pack(s, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, c);
            4'd4:  return pack(s, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, c);
            4'd5:  return pack(s, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, c);
            4'd6:  return pack(s, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, c);
            4'd7:  return pack(s, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, c);
            4'd8:  return pack(s, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 0, c);
            4'd9:  return pack(s, 0, 1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0, c);
            4'd10: return pack(s, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 0, c);
            default: return pack(s, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, c);
        endcase
    endfunction

    function automatic logic [22:0] reset_exp(input logic [3:0] s, input logic [3:0] c);
        return pack(s, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, c);
    endfunction

    // Monitor: one expected entry per clock cycle, checked mid-cycle.
    always @(negedge clk) begin
        logic [22:0] act, exp;
        cyc++;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            act = {state, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, AdrSrc,
                   ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal, instret};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL outputs cycle=%0d got=%06h want=%06h (state got=%0d want=%0d)",
                         cyc, act, exp, act[22:19], exp[22:19]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Run one instruction from FETCH; seq lists states low nibble first.
    task automatic run_instr(input logic [6:0] op_v, input logic [19:0] seq, input int n,
                             input bit is_ill);
        logic [3:0] s;
        op = op_v;
        for (int i = 0; i < n; i++) begin
            s = seq[4*i +: 4];
            exp_q.push_back(model(s, is_ill && (s == 4'd1), cnt[3:0]));
        end
        tick(n);
        if (!is_ill) cnt++;
    endtask

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    initial begin
        // Reset held across three edges; outputs forced low, state already FETCH.
        reset = 1'b1;
        op = OP_R;
        tick(1);
        exp_q.push_back(reset_exp(4'd0, 4'd0));
        exp_q.push_back(reset_exp(4'd0, 4'd0));
        tick(2);
        reset = 1'b0;

        run_instr(OP_R,   20'h07610, 4, 0);
        run_instr(OP_LW,  20'h43210, 5, 0);
        run_instr(OP_SW,  20'h05210, 4, 0);
        run_instr(OP_BR,  20'h00A10, 3, 0);
        run_instr(OP_JAL, 20'h07910, 4, 0);
        run_instr(OP_SYS, 20'h00010, 2, 1);
        run_instr(7'b1111111, 20'h00010, 2, 1);
        run_instr(OP_I,   20'h07810, 4, 0);

        // op changes outside DECODE/MEMADR are ignored: swap it mid-R-type.
        op = OP_R;
        exp_q.push_back(model(4'd0, 0, cnt[3:0]));
        exp_q.push_back(model(4'd1, 0, cnt[3:0]));
        tick(2);
        op = OP_SYS;
        exp_q.push_back(model(4'd6, 0, cnt[3:0]));
        exp_q.push_back(model(4'd7, 0, cnt[3:0]));
        tick(2);
        cnt++;

`ifdef MC_MEM_WAIT_EN
        // Three stalled FETCH cycles: no IRWrite/PCUpdate until memory is ready.
        mem_ready = 1'b0;
        repeat (3) exp_q.push_back(model(4'd0, 0, cnt[3:0]) & ~(23'h3 << 17));
        tick(3);
        mem_ready = 1'b1;
        run_instr(OP_R, 20'h07610, 4, 0);
        // sw with two stalled MEMWRITE cycles: MemWrite held for three cycles.
        op = OP_SW;
        exp_q.push_back(model(4'd0, 0, cnt[3:0]));
        exp_q.push_back(model(4'd1, 0, cnt[3:0]));
        exp_q.push_back(model(4'd2, 0, cnt[3:0]));
        tick(3);
        mem_ready = 1'b0;
        exp_q.push_back(model(4'd5, 0, cnt[3:0]));
        exp_q.push_back(model(4'd5, 0, cnt[3:0]));
        tick(2);
        mem_ready = 1'b1;
        exp_q.push_back(model(4'd5, 0, cnt[3:0]));
        tick(1);
        cnt++;
`else
        // Without wait states mem_ready is ignored entirely.
        mem_ready = 1'b0;
        run_instr(OP_LW, 20'h43210, 5, 0);
        run_instr(OP_SW, 20'h05210, 4, 0);
        mem_ready = 1'b1;
`endif

        // Drive the 4-bit counter up to 15, then one more to wrap to 0.
        while ((cnt % 16) != 15) run_instr(OP_R, 20'h07610, 4, 0);
        run_instr(OP_BR, 20'h00A10, 3, 0);
        run_instr(OP_R, 20'h07610, 4, 0);

        // Reset during MEMREAD: abandoned with no writes, counter cleared.
        op = OP_LW;
        exp_q.push_back(model(4'd0, 0, cnt[3:0]));
        exp_q.push_back(model(4'd1, 0, cnt[3:0]));
        exp_q.push_back(model(4'd2, 0, cnt[3:0]));
        tick(3);
        reset = 1'b1;
        exp_q.push_back(reset_exp(4'd3, cnt[3:0]));
        tick(1);
        reset = 1'b0;
        cnt = 0;
        run_instr(OP_R, 20'h07610, 4, 0);
        run_instr(OP_JAL, 20'h07910, 4, 0);

        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_main_fsm.md
# mc_main_fsm

Main sequencing controller for the multi-cycle RV32I core. A Moore state machine walks each instruction through Fetch, Decode and per-class execute/writeback states. It drives every datapath enable and mux select: IR/PC/register-file/memory write enables, ALU operand selects, ALUOp and result select. It also emits `Branch` and `PCUpdate`, which the branch decoder combines with the ALU flags into `PCWrite`.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports (clock and reset first):
- `clk`  in  1  core clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  7  opcode field from the instruction register; sampled in DECODE only.
- `mem_ready`  in  1  unified memory ready; used only when the macro is defined (see Configuration).
- `IRWrite`  out  1  load the instruction register.
- `PCUpdate`  out  1  unconditional PC write request to the branch decoder.
- `Branch`  out  1  conditional PC write request to the branch decoder.
- `RegWrite`  out  1  register-file write enable.
- `MemWrite`  out  1  data-memory write enable.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = rs1 data.
- `ALUSrcB`  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- `ALUOp`  out  2  00 = add, 01 = subtract/compare, 10 = decode by funct.
- `ResultSrc`  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result.
- `illegal`  out  1  one-cycle pulse, asserted in DECODE for an unsupported opcode.
- `instret`  out  CNT_W  count of retired instructions.
- `state`  out  4  current state encoding, for debug.

## Operation
State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10. Codes 11–15 are unused and go to FETCH on the next edge.

Per-state outputs. Anything not listed is 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. This computes the branch/jump target.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.

Transitions:
- FETCH goes to DECODE.
- DECODE branches on `op`:
  - 0000011 (lw) or 0100011 (sw) → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BRANCH
  - any other value → FETCH, with `illegal`=1 for that cycle.
- MEMADR goes to MEMREAD if `op`=0000011, otherwise to MEMWRITE.
- Other fixed transitions: MEMREAD → MEMWB; EXECR and EXECI → ALUWB; JAL → ALUWB.
- MEMWB, MEMWRITE, ALUWB and BRANCH go to FETCH.

Retirement counting:
- `instret` increments by 1 on every edge that leaves MEMWB, MEMWRITE, ALUWB or BRANCH for FETCH.
- It wraps modulo 2^CNT_W.
- Illegal opcodes are not counted.

Reset:
- While `reset`=1, all enables and `illegal` are forced to 0 and all selects to 00/0.
- On the edge where `reset`=1: state ← FETCH and `instret` ← 0.
- A reset asserted mid-instruction abandons that instruction without asserting any write enable in the reset cycle.

## Timing
- Outputs are a combinational decode of `state` and `reset`, plus `op` for `illegal`. No output register.
- Cycles per instruction, FETCH through last state, with no wait states:
  - lw 5; sw 4; R-type 4; I-type 4; jal 4; branch 3.
  - Illegal opcode: 2 (FETCH, DECODE).
- The first FETCH is the cycle after `reset` deasserts.
- `op` changes while outside DECODE and MEMADR have no effect.

## Configuration
- `MC_MEM_WAIT_EN` defined:
  - FETCH, MEMREAD and MEMWRITE hold their state while `mem_ready`=0.
  - In FETCH, IRWrite and PCUpdate are asserted only in the cycle where `mem_ready`=1, so the PC advances exactly once per fetch.
  - MemWrite stays asserted throughout MEMWRITE. Leaving MEMWRITE requires `mem_ready`=1, and `instret` increments on that exit.
  - Each stall cycle adds 1 to the latencies above.
- `MC_MEM_WAIT_EN` undefined: `mem_ready` is ignored and memory is assumed ready every cycle.

## Test plan
- Reset held 3 cycles, then released with `op`=0110011: all enables are 0 during reset; the state sequence is 0,1,6,7,0; RegWrite=1 only in the ALUWB cycle; `instret`=1 after the sequence.
- `op`=0000011: states 0,1,2,3,4,0; AdrSrc=1 in MEMREAD; ResultSrc=01 with RegWrite=1 in MEMWB. `op`=0100011: states 0,1,2,5,0 with MemWrite=1 for exactly 1 cycle.
- `op`=1100011: states 0,1,10,0 with Branch=1 and ALUOp=01 for 1 cycle and PCUpdate=0 in BRANCH. `op`=1101111: states 0,1,9,7,0 with PCUpdate=1 in JAL.
- `op`=1110011: `illegal` pulses for 1 cycle in DECODE, the next state is FETCH, and `instret` is unchanged.
- With `MC_MEM_WAIT_EN` defined and `mem_ready` low for 3 cycles in FETCH: state stays 0 for 4 cycles and IRWrite/PCUpdate are high only in the 4th. A sw with `mem_ready` low for 2 MEMWRITE cycles gives MemWrite=1 for 3 cycles.
- Preload `instret`=2^CNT_W−1 via a CNT_W=4 build running 15 R-type instructions, then retire one more: `instret` wraps to 0. Asserting reset in MEMREAD returns state to 0 and `instret` to 0 with no RegWrite.
